sdcmd_arbiter: RTL and testbench

Two-requester command arbiter for the SD-card SPI command path. It replaces the OR-merge between the initialisation sequencer and the disk manager. It latches each requester's command pulse and grants the shared prepare/manager path to one requester at a time, using round-robin order. It holds the granted command stable until the downstream completion strobe or a timeout, then returns a done or error pulse to the owning requester.

---
 rtl/sdcmd_arbiter_if.sv | 27 ++
 rtl/sdcmd_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdcmd_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcmd_arbiter_if.sv
// Requester and downstream signals of the SD command arbiter.
// The arbiter takes the slave view; the master view is the requesters plus the downstream path.
interface sdcmd_arbiter_if;
  logic [5:0]  cmd0, cmd1;
  logic [31:0] arg0, arg1;
  logic        sta0, sta1, sta400, sta401;
  logic        readit0, readit1, init0, init1;
  logic        rdy;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        sta, sta40, readit, init, busy, owner;
  logic        done0, done1, err0, err1, ovf0, ovf1, abort;

  modport slave (
    input  cmd0, cmd1, arg0, arg1, sta0, sta1, sta400, sta401,
           readit0, readit1, init0, init1, rdy,
    output cmd, arg, sta, sta40, readit, init, busy, owner,
           done0, done1, err0, err1, ovf0, ovf1, abort
  );

  modport master (
    output cmd0, cmd1, arg0, arg1, sta0, sta1, sta400, sta401,
           readit0, readit1, init0, init1, rdy,
    input  cmd, arg, sta, sta40, readit, init, busy, owner,
           done0, done1, err0, err1, ovf0, ovf1, abort
  );
endinterface

// File: rtl/sdcmd_arbiter.sv
// Round-robin arbiter with one pending slot per port: grant one cycle after the slot fills,
// hold until rdy or timeout; requests that find no free slot are dropped and reported via ovf.
module sdcmd_arbiter #(
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst,
  sdcmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Expiry is taken on the edge where the counter would step onto TIMEOUT-1.
  localparam logic [15:0] LAST = 16'(TIMEOUT - 2);

  state_t      state;
  logic [15:0] cnt;
  logic        rr_last;
  logic [1:0]  vld, kind, rd, in;
  logic [5:0]  scmd [2];
  logic [31:0] sarg [2];

  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  logic        sta_q, sta40_q, rd_q, in_q, busy_q, owner_q, abort_q;
  logic [1:0]  done_q, err_q, ovf_q, ovf_def;

  logic [1:0]  req, req40, rd_i, in_i;
  logic [5:0]  cmd_i [2];
  logic [31:0] arg_i [2];
  logic        grant, sel;
  logic [1:0]  take, accept, drop, rel_done, rel_err, ovf_want, rel_any;

  assign req40    = {bus.sta401, bus.sta400};
  assign req      = {bus.sta1, bus.sta0} | req40;
  assign rd_i     = {bus.readit1, bus.readit0};
  assign in_i     = {bus.init1, bus.init0};
  assign cmd_i[0] = bus.cmd0;
  assign cmd_i[1] = bus.cmd1;
  assign arg_i[0] = bus.arg0;
  assign arg_i[1] = bus.arg1;

  assign grant = (state == IDLE) && (vld != 2'b00);
  assign sel   = (vld == 2'b11) ? ~rr_last : vld[1];
  assign take  = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // A slot being emptied by this grant edge may refill; the active owner's port may not.
  assign accept[0] = (!vld[0] || take[0]) && !(busy_q && !owner_q);
  assign accept[1] = (!vld[1] || take[1]) && !(busy_q && owner_q);
  assign drop      = req & ~accept;

  assign rel_done = (state == WAIT && bus.rdy) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rel_err  = (state == WAIT && !bus.rdy && cnt == LAST) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rel_any  = rel_done | rel_err;
  assign ovf_want = drop | ovf_def;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_last <= 1'b1;
      vld     <= '0;
      kind    <= '0;
      rd      <= '0;
      in      <= '0;
      for (int i = 0; i < 2; i++) begin
        scmd[i] <= '0;
        sarg[i] <= '0;
      end
      cmd_q   <= '0;
      arg_q   <= '0;
      sta_q   <= 1'b0;
      sta40_q <= 1'b0;
      rd_q    <= 1'b0;
      in_q    <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      ovf_q   <= '0;
      ovf_def <= '0;
    end else begin
      sta_q   <= 1'b0;
      sta40_q <= 1'b0;
      done_q  <= rel_done;
      err_q   <= rel_err;
      abort_q <= |rel_err;
      // An overflow colliding with done/err on the same port is pushed back one cycle.
      ovf_q   <= ovf_want & ~rel_any;
      ovf_def <= ovf_want & rel_any;

      for (int i = 0; i < 2; i++) begin
        if (req[i] && accept[i]) begin
          vld[i]  <= 1'b1;
          kind[i] <= req40[i];
          rd[i]   <= rd_i[i];
          in[i]   <= in_i[i];
          scmd[i] <= cmd_i[i];
          sarg[i] <= arg_i[i];
        end else if (take[i]) begin
          vld[i] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (grant) begin
            cmd_q   <= scmd[sel];
            arg_q   <= sarg[sel];
            rd_q    <= rd[sel];
            in_q    <= in[sel];
            sta_q   <= ~kind[sel];
            sta40_q <= kind[sel];
            busy_q  <= 1'b1;
            owner_q <= sel;
            rr_last <= sel;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.rdy || cnt == LAST) begin
            cmd_q  <= '0;
            arg_q  <= '0;
            rd_q   <= 1'b0;
            in_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd    = cmd_q;
  assign bus.arg    = arg_q;
  assign bus.sta    = sta_q;
  assign bus.sta40  = sta40_q;
  assign bus.readit = rd_q;
  assign bus.init   = in_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;
  assign bus.done0  = done_q[0];
  assign bus.done1  = done_q[1];
  assign bus.err0   = err_q[0];
  assign bus.err1   = err_q[1];
  assign bus.ovf0   = ovf_q[0];
  assign bus.ovf1   = ovf_q[1];
  assign bus.abort  = abort_q;
endmodule

// File: tb/tb_sdcmd_arbiter.sv
// Scoreboard bench for sdcmd_arbiter: directed requests push timed expected events,
// a negedge monitor pops and compares whenever any output pulse appears.
module tb_sdcmd_arbiter;
  localparam logic [8:0] STA   = 9'h001, STA40 = 9'h002, DONE0 = 9'h004, DONE1 = 9'h008;
  localparam logic [8:0] ERR0  = 9'h010, ERR1  = 9'h020, OVF0  = 9'h040, OVF1  = 9'h080;
  localparam logic [8:0] ABORT = 9'h100;

  typedef struct {
    int          cyc;
    logic [8:0]  ev;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        rd;
    logic        in;
    logic        own;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  sdcmd_arbiter_if b();

  sdcmd_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cyc %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endfunction

  function automatic void push(input int c, input logic [8:0] ev, input logic [5:0] cm,
                               input logic [31:0] ar, input bit rd, input bit in, input bit own);
    exp_t e;
    e.cyc = c; e.ev = ev; e.cmd = cm; e.arg = ar; e.rd = rd; e.in = in; e.own = own;
    exp_q.push_back(e);
  endfunction

  // Monitor: any pulse on an event output must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [8:0] ev;
    exp_t e;
    ev = {b.abort, b.ovf1, b.ovf0, b.err1, b.err0, b.done1, b.done0, b.sta40, b.sta};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event cyc=%0d: actual=none required=%b", e.cyc, e.ev);
    end
    if (ev != 9'd0) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cyc=%0d: actual=%b required=none", cyc, ev);
      end else begin
        e = exp_q.pop_front();
        chk("event_bits", 32'(ev), 32'(e.ev));
        if ((e.ev & (STA | STA40)) != 9'd0) begin
          chk("grant_cmd", 32'(b.cmd), 32'(e.cmd));
          chk("grant_arg", b.arg, e.arg);
          chk("grant_flags", {30'd0, b.readit, b.init}, {30'd0, e.rd, e.in});
          chk("grant_owner", 32'(b.owner), 32'(e.own));
          chk("grant_busy", 32'(b.busy), 32'd1);
        end else if ((e.ev & (DONE0 | DONE1 | ERR0 | ERR1)) != 9'd0) begin
          chk("release_busy", 32'(b.busy), 32'd0);
          chk("release_cmd", 32'(b.cmd), 32'd0);
          chk("release_arg", b.arg, 32'd0);
          chk("release_flags", {30'd0, b.readit, b.init}, 32'd0);
          chk("release_owner", 32'(b.owner), 32'(e.own));
        end
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clr();
    b.sta0 = 1'b0; b.sta1 = 1'b0; b.sta400 = 1'b0; b.sta401 = 1'b0;
  endtask

  task automatic issue(input bit p, input bit k40, input logic [5:0] c, input logic [31:0] a,
                       input bit rd, input bit in);
    if (p == 1'b0) begin
      b.cmd0 = c; b.arg0 = a; b.readit0 = rd; b.init0 = in;
      if (k40) b.sta400 = 1'b1; else b.sta0 = 1'b1;
    end else begin
      b.cmd1 = c; b.arg1 = a; b.readit1 = rd; b.init1 = in;
      if (k40) b.sta401 = 1'b1; else b.sta1 = 1'b1;
    end
  endtask

  task automatic pulse_rdy();
    b.rdy = 1'b1;
    @(negedge clk);
    b.rdy = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd"}, 32'(b.cmd), 32'd0);
    chk({tag, "_arg"}, b.arg, 32'd0);
    chk({tag, "_busy_owner"}, {30'd0, b.busy, b.owner}, 32'd0);
    chk({tag, "_pulses"}, {19'd0, b.sta, b.sta40, b.readit, b.init, b.done0, b.done1,
                           b.err0, b.err1, b.ovf0, b.ovf1, b.abort}, 32'd0);
  endtask

  // One request, released by rdy two cycles into WAIT.
  task automatic single(input bit p, input bit k40, input logic [5:0] c, input logic [31:0] a,
                        input bit rd, input bit in);
    int t;
    @(negedge clk);
    t = cyc;
    issue(p, k40, c, a, rd, in);
    push(t + 2, k40 ? STA40 : STA, c, a, rd, in, p);
    push(t + 5, p ? DONE1 : DONE0, 6'd0, 32'd0, 1'b0, 1'b0, p);
    @(negedge clk);
    clr();
    at(t + 4); pulse_rdy(); at(t + 6);
  endtask

  // Both ports request in the same cycle; 'first' is the port that must win.
  task automatic pair(input bit first, input logic [5:0] c0, input logic [5:0] c1, input bit k1);
    int t;
    logic [31:0] a0, a1;
    a0 = 32'h1000_0000 | 32'(c0);
    a1 = 32'h2000_0000 | 32'(c1);
    @(negedge clk);
    t = cyc;
    issue(1'b0, 1'b0, c0, a0, 1'b0, 1'b1);
    issue(1'b1, k1, c1, a1, 1'b1, 1'b0);
    if (first == 1'b0) begin
      push(t + 2, STA, c0, a0, 1'b0, 1'b1, 1'b0);
      push(t + 5, DONE0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      push(t + 6, k1 ? STA40 : STA, c1, a1, 1'b1, 1'b0, 1'b1);
      push(t + 9, DONE1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    end else begin
      push(t + 2, k1 ? STA40 : STA, c1, a1, 1'b1, 1'b0, 1'b1);
      push(t + 5, DONE1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      push(t + 6, STA, c0, a0, 1'b0, 1'b1, 1'b0);
      push(t + 9, DONE0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    clr();
    at(t + 4); pulse_rdy(); at(t + 8); pulse_rdy(); at(t + 10);
  endtask

  initial begin
    int t;
    b.cmd0 = '0; b.cmd1 = '0; b.arg0 = '0; b.arg1 = '0;
    b.readit0 = 1'b0; b.readit1 = 1'b0; b.init0 = 1'b0; b.init1 = 1'b0;
    b.rdy = 1'b0;
    clr();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // rdy while idle must not produce anything
    pulse_rdy();
    repeat (2) @(negedge clk);

    single(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
    pair(1'b1, 6'd11, 6'd12, 1'b0);
    single(1'b1, 1'b1, 6'd13, 32'hCAFE_0013, 1'b1, 1'b1);
    pair(1'b0, 6'd3, 6'd41, 1'b1);

    // Overflow: owner-port drop, second port-1 drop, and a drop colliding with done0
    @(negedge clk);
    t = cyc;
    issue(1'b0, 1'b0, 6'd5, 32'h0000_0055, 1'b0, 1'b0);
    push(t + 2, STA, 6'd5, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    at(t + 3);
    issue(1'b1, 1'b0, 6'd20, 32'h0000_2020, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 6'd6, 32'h0000_0066, 1'b0, 1'b0);
    push(t + 4, OVF0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    issue(1'b1, 1'b0, 6'd21, 32'h0000_2121, 1'b0, 1'b1);
    push(t + 5, OVF1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    at(t + 6);
    b.rdy = 1'b1;
    issue(1'b0, 1'b0, 6'd7, 32'h0000_0077, 1'b0, 1'b0);
    push(t + 7, DONE0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    push(t + 8, STA | OVF0, 6'd20, 32'h0000_2020, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    b.rdy = 1'b0;
    clr();
    at(t + 10); pulse_rdy();
    push(t + 11, DONE1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    at(t + 13);

    // Timeout on port 0 with port 1 queued behind it
    @(negedge clk);
    t = cyc;
    issue(1'b0, 1'b0, 6'd1, 32'h0001_0001, 1'b0, 1'b0);
    push(t + 2, STA, 6'd1, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    at(t + 3);
    issue(1'b1, 1'b0, 6'd2, 32'h0002_0002, 1'b0, 1'b1);
    push(t + 18, ERR0 | ABORT, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    push(t + 19, STA, 6'd2, 32'h0002_0002, 1'b0, 1'b1, 1'b1);
    push(t + 22, DONE1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clr();
    at(t + 21); pulse_rdy(); at(t + 24);

    // Reset in WAIT with port 0 pending: silent abort, pending slot lost
    @(negedge clk);
    t = cyc;
    issue(1'b1, 1'b0, 6'd9, 32'h0909_0909, 1'b1, 1'b1);
    push(t + 2, STA, 6'd9, 32'h0909_0909, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    clr();
    at(t + 3);
    issue(1'b0, 1'b0, 6'd10, 32'h1010_1010, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    at(t + 5);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    pair(1'b0, 6'd8, 6'd17, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
